// File: rtl/check_flit_channel_type_is_in_order.sv
// check_flit_channel_type_is_in_order
//
// Purpose:
//   This is a protocol checker for one router input port. For every virtual
//   channel it follows the flit write channel and checks that flits arrive in
//   the order header -> zero or more body flits -> tail. It also checks the
//   minimum packet length and that the VC select is one-hot. The block only
//   watches the traffic and raises error flags; it never changes the traffic.
//
// Ports:
//   clk            in   1   clock; all state updates happen on the rising edge
//   reset          in   1   asynchronous, active-low reset
//   hdr_flg_in     in   1   header flag of the incoming flit
//   tail_flg_in    in   1   tail flag of the incoming flit
//   flit_in_wr     in   1   flit valid this cycle; all other inputs are ignored when low
//   vc_num_in      in   V   one-hot VC of the incoming flit
//   error_pulse_o  out  1   high for one cycle after any violation
//   error_o        out  1   sticky flag, set on the first violation
//   error_code_o   out  3   code of the first violation
//   error_vc_o     out  V   vc_num_in value of the first violation
//
// Error codes: 0 none, 1 header while active, 2 body/tail with no header,
//              3 short packet, 4 VC not one-hot, 5 single-flit violation.
module check_flit_channel_type_is_in_order #(
   parameter int    V            = 4,
   parameter string PCK_TYPE     = "MULTI_FLIT",
   parameter int    MIN_PCK_SIZE = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         hdr_flg_in,
   input  logic         tail_flg_in,
   input  logic         flit_in_wr,
   input  logic [V-1:0] vc_num_in,
   output logic         error_pulse_o,
   output logic         error_o,
   output logic [2:0]   error_code_o,
   output logic [V-1:0] error_vc_o
);

   typedef enum logic [2:0] {
      ERR_NONE         = 3'd0,
      ERR_HDR_ACTIVE   = 3'd1,
      ERR_NO_HDR       = 3'd2,
      ERR_SHORT        = 3'd3,
      ERR_VC_ONEHOT    = 3'd4,
      ERR_SINGLE_FLIT  = 3'd5
   } err_code_e;

   localparam bit       SINGLE_MODE = (PCK_TYPE == "SINGLE_FLIT");
   localparam bit       MIN_GT1     = (MIN_PCK_SIZE > 1);
   localparam logic [4:0] MIN5      = 5'(MIN_PCK_SIZE);

   // Per-VC state: an ACTIVE bit (a header has been seen and no tail yet)
   // and a flit counter that saturates at 15.
   logic [V-1:0] active_q, active_d;
   logic [3:0]   cnt_q [V];
   logic [3:0]   cnt_d [V];

   logic         error_pulse_q, error_pulse_d;
   logic         error_q, error_d;
   err_code_e    error_code_q, error_code_d;
   logic [V-1:0] error_vc_q, error_vc_d;

   err_code_e    code_new;
   logic         sel_active;
   logic [3:0]   sel_cnt;
   logic [3:0]   cnt_inc;

   always_comb begin
      active_d = active_q;
      for (int i = 0; i < V; i++) cnt_d[i] = cnt_q[i];
      code_new = ERR_NONE;

      // State of the selected VC. The values are only used when vc_num_in is
      // one-hot, so OR-ing the masked entries gives exactly one VC's state.
      sel_active = |(active_q & vc_num_in);
      sel_cnt    = '0;
      for (int i = 0; i < V; i++) begin
         if (vc_num_in[i]) sel_cnt = sel_cnt | cnt_q[i];
      end
      cnt_inc = (sel_cnt == 4'd15) ? 4'd15 : sel_cnt + 4'd1;

      if (flit_in_wr) begin
         if (!$onehot(vc_num_in)) begin
            code_new = ERR_VC_ONEHOT;
         end else if (SINGLE_MODE && !(hdr_flg_in && tail_flg_in)) begin
            code_new = ERR_SINGLE_FLIT;
         end else begin
            case ({hdr_flg_in, tail_flg_in})
               2'b11: begin
                  if (sel_active)   code_new = ERR_HDR_ACTIVE;
                  else if (MIN_GT1) code_new = ERR_SHORT;
               end
               2'b10: begin
                  if (sel_active) code_new = ERR_HDR_ACTIVE;
               end
               2'b00: begin
                  if (!sel_active) code_new = ERR_NO_HDR;
               end
               default: begin
                  // This is a tail. The packet length includes this flit,
                  // so the check is count+1. Using 5 bits avoids a wrap
                  // when the counter has saturated.
                  if (!sel_active)                           code_new = ERR_NO_HDR;
                  else if (({1'b0, sel_cnt} + 5'd1) < MIN5)  code_new = ERR_SHORT;
               end
            endcase

            for (int i = 0; i < V; i++) begin
               if (vc_num_in[i]) begin
                  case ({hdr_flg_in, tail_flg_in})
                     2'b10: begin
                        // A new header abandons any packet that was in flight.
                        active_d[i] = 1'b1;
                        cnt_d[i]    = 4'd1;
                     end
                     2'b00: begin
                        if (active_q[i]) cnt_d[i] = cnt_inc;
                     end
                     default: begin
                        active_d[i] = 1'b0;
                        cnt_d[i]    = 4'd0;
                     end
                  endcase
               end
            end
         end
      end

      // Only the first violation is captured. Later violations still pulse.
      error_pulse_d = (code_new != ERR_NONE);
      error_d       = error_q;
      error_code_d  = error_code_q;
      error_vc_d    = error_vc_q;
      if (!error_q && code_new != ERR_NONE) begin
         error_d      = 1'b1;
         error_code_d = code_new;
         error_vc_d   = vc_num_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_q      <= '0;
         for (int i = 0; i < V; i++) cnt_q[i] <= 4'd0;
         error_pulse_q <= 1'b0;
         error_q       <= 1'b0;
         error_code_q  <= ERR_NONE;
         error_vc_q    <= '0;
      end else begin
         active_q      <= active_d;
         for (int i = 0; i < V; i++) cnt_q[i] <= cnt_d[i];
         error_pulse_q <= error_pulse_d;
         error_q       <= error_d;
         error_code_q  <= error_code_d;
         error_vc_q    <= error_vc_d;
      end
   end

   assign error_pulse_o = error_pulse_q;
   assign error_o       = error_q;
   assign error_code_o  = error_code_q;
   assign error_vc_o    = error_vc_q;

endmodule

// File: tb/tb_check_flit_channel_type_is_in_order.sv
// Testbench for check_flit_channel_type_is_in_order. Three checker instances
// (MULTI_FLIT with MIN=2, MULTI_FLIT with MIN=3, and SINGLE_FLIT with MIN=1)
// all watch the same flit stream. Each directed scenario checks the instance
// it targets against expected values worked out by hand.
module tb_check_flit_channel_type_is_in_order;

   localparam int V = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         hdr = 1'b0, tail = 1'b0, wr = 1'b0;
   logic [V-1:0] vc = '0;

   logic         p2, e2, p3, e3, ps, es;
   logic [2:0]   c2, c3, cs;
   logic [V-1:0] v2, v3, vs;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   check_flit_channel_type_is_in_order #(.V(V), .PCK_TYPE("MULTI_FLIT"), .MIN_PCK_SIZE(2)) dut_m2 (
      .clk(clk), .reset(reset), .hdr_flg_in(hdr), .tail_flg_in(tail), .flit_in_wr(wr),
      .vc_num_in(vc), .error_pulse_o(p2), .error_o(e2), .error_code_o(c2), .error_vc_o(v2));

   check_flit_channel_type_is_in_order #(.V(V), .PCK_TYPE("MULTI_FLIT"), .MIN_PCK_SIZE(3)) dut_m3 (
      .clk(clk), .reset(reset), .hdr_flg_in(hdr), .tail_flg_in(tail), .flit_in_wr(wr),
      .vc_num_in(vc), .error_pulse_o(p3), .error_o(e3), .error_code_o(c3), .error_vc_o(v3));

   check_flit_channel_type_is_in_order #(.V(V), .PCK_TYPE("SINGLE_FLIT"), .MIN_PCK_SIZE(1)) dut_s (
      .clk(clk), .reset(reset), .hdr_flg_in(hdr), .tail_flg_in(tail), .flit_in_wr(wr),
      .vc_num_in(vc), .error_pulse_o(ps), .error_o(es), .error_code_o(cs), .error_vc_o(vs));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge. Drives one flit and returns at the next negedge.
   // At that point the outputs show the result of this flit.
   task automatic flit(input logic h, input logic t, input logic w, input logic [V-1:0] v);
      hdr = h; tail = t; wr = w; vc = v;
      @(negedge clk);
      $display("flit h=%0b t=%0b wr=%0b vc=%b -> m2:p%0b c%0d m3:p%0b c%0d s:p%0b c%0d",
               h, t, w, v, p2, c2, p3, c3, ps, cs);
   endtask

   task automatic do_reset();
      wr = 1'b0; hdr = 1'b0; tail = 1'b0; vc = '0;
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      do_reset();
      // Reset state
      check_val("rst_err",   e2, 0);
      check_val("rst_code",  c2, 0);
      check_val("rst_vc",    v2, 0);
      check_val("rst_pulse", p2, 0);

      // Clean interleaved stream on the MIN=2 instance
      flit(1, 0, 1, 4'b0001); check_val("clean_p0", p2, 0);
      flit(1, 0, 1, 4'b0010); check_val("clean_p1", p2, 0);
      flit(0, 0, 1, 4'b0001); check_val("clean_p2", p2, 0);
      flit(0, 1, 1, 4'b0010); check_val("clean_p3", p2, 0);
      flit(0, 1, 1, 4'b0001); check_val("clean_p4", p2, 0);
      check_val("clean_err", e2, 0);

      // Two headers on VC2
      flit(1, 0, 1, 4'b0100); check_val("hh_p0", p2, 0);
      flit(1, 0, 1, 4'b0100); check_val("hh_p1", p2, 1);
      check_val("hh_err",  e2, 1);
      check_val("hh_code", c2, 1);
      check_val("hh_vc",   v2, 4'b0100);
      flit(0, 1, 1, 4'b0100); check_val("hh_tail_p", p2, 0);
      check_val("hh_tail_code", c2, 1);

      // Body with no header, then a tail with no header
      do_reset();
      flit(0, 0, 1, 4'b1000); check_val("nohdr_p",    p2, 1);
      check_val("nohdr_code", c2, 2);
      check_val("nohdr_vc",   v2, 4'b1000);
      flit(0, 1, 1, 4'b1000); check_val("nohdr_tail_p", p2, 1);
      check_val("nohdr_tail_code", c2, 2);
      flit(0, 0, 0, 4'b0000); check_val("idle_p", p2, 0);

      // Minimum length 3
      do_reset();
      flit(1, 0, 1, 4'b0001); check_val("m3_hdr_p", p3, 0);
      flit(0, 1, 1, 4'b0001); check_val("m3_short_p", p3, 1);
      check_val("m3_short_code", c3, 3);
      check_val("m3_short_vc",   v3, 4'b0001);
      flit(1, 0, 1, 4'b0010); check_val("m3_ok_p0", p3, 0);
      flit(0, 0, 1, 4'b0010); check_val("m3_ok_p1", p3, 0);
      flit(0, 1, 1, 4'b0010); check_val("m3_ok_p2", p3, 0);
      do_reset();
      flit(1, 1, 1, 4'b0100); check_val("m3_ht_p", p3, 1);
      check_val("m3_ht_code", c3, 3);
      check_val("m2_ht_code", c2, 3);

      // A header while active takes priority over a short packet
      do_reset();
      flit(1, 0, 1, 4'b0001);
      flit(1, 1, 1, 4'b0001); check_val("prio_code", c2, 1);

      // VC select that is not one-hot leaves the VC state unchanged
      do_reset();
      flit(1, 0, 1, 4'b0010); check_val("oh_hdr_p", p2, 0);
      flit(0, 1, 1, 4'b0110); check_val("oh_p", p2, 1);
      check_val("oh_code", c2, 4);
      check_val("oh_vc",   v2, 4'b0110);
      flit(0, 0, 1, 4'b0010); check_val("oh_still_active", p2, 0);
      flit(0, 0, 0, 4'b0000); check_val("oh_wr0_p", p2, 0);
      flit(0, 0, 1, 4'b0000); check_val("oh_zero_p", p2, 1);
      check_val("oh_zero_code", c2, 4);

      // Single-flit mode, and an asynchronous reset in the middle of the stream
      do_reset();
      for (int i = 0; i < V; i++) begin
         flit(1, 1, 1, 4'(1 << i)); check_val("sf_ok_p", ps, 0);
      end
      check_val("sf_ok_err", es, 0);
      flit(1, 0, 1, 4'b0010); check_val("sf_bad_p", ps, 1);
      check_val("sf_bad_code", cs, 5);
      check_val("sf_bad_vc",   vs, 4'b0010);
      wr = 1'b0;
      reset = 1'b0;
      #1;
      check_val("async_err",  es, 0);
      check_val("async_code", cs, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
